// File: rtl/ssd_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver.
// Glyphs are active-low, bit 6 = Ca ... bit 0 = Cg.
package ssd_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int unsigned max_digits();
    return 8;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational 4-bit code to active-low cathode pattern; code F is blank.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (code)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed N-digit seven-segment driver with frame-synchronous double
// buffering, per-digit blink, leading-zero blanking and anode dead-time.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SCAN_DIV_BITS = 18,
  parameter int unsigned DEADTIME      = 16,
  parameter int unsigned BLINK_LOG2    = 5
) (
  input  logic                    board_clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lzb,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp_out,
  output logic                    frame_tick
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned FC_W   = (BLINK_LOG2 > 0) ? BLINK_LOG2 : 1;
  localparam logic [SCAN_DIV_BITS-1:0] PRESC_MAX = '1;
  localparam logic [SCAN_DIV_BITS-1:0] DEAD_END  = SCAN_DIV_BITS'(DEADTIME);
  localparam logic [IDX_W-1:0]         IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  if (NUM_DIGITS == 0 || NUM_DIGITS > max_digits()) begin : g_bad_num_digits
    $error("ssd_scan_driver: NUM_DIGITS out of range");
  end
  if ((64'(DEADTIME) >> SCAN_DIV_BITS) != 0) begin : g_bad_deadtime
    $error("ssd_scan_driver: DEADTIME must be below 2**SCAN_DIV_BITS");
  end

  logic [SCAN_DIV_BITS-1:0] presc;
  logic [IDX_W-1:0]         idx;
  logic [FC_W-1:0]          frame_cnt;
  logic                     blink_phase;
  logic                     pending;

  logic [DATA_W-1:0]        shadow_digits, active_digits;
  logic [NUM_DIGITS-1:0]    shadow_dp,     active_dp;
  logic [NUM_DIGITS-1:0]    shadow_blink,  active_blink;

  logic                     scan_wrap_c, frame_wrap_c;
  logic [NUM_DIGITS-1:0]    lz_mask_c;
  logic                     zero_run_c;
  logic [3:0]               cur_nibble_c, code_c;
  logic                     blink_blank_c;
  logic [6:0]               seg_c;

  assign scan_wrap_c  = (presc == PRESC_MAX);
  assign frame_wrap_c = scan_wrap_c && (idx == IDX_LAST);

  // Prescaler, scan index, frame counter and blink phase
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      presc      <= presc + SCAN_DIV_BITS'(1);
      frame_tick <= frame_wrap_c;
      if (scan_wrap_c) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (frame_wrap_c) begin
        frame_cnt <= frame_cnt + FC_W'(1);
        if (frame_cnt == '1) begin
          blink_phase <= ~blink_phase;
        end
      end
    end
  end

  // Shadow capture and frame-boundary commit; a load racing a commit stays pending
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      shadow_digits <= {NUM_DIGITS{BLANK_CODE}};
      shadow_dp     <= '0;
      shadow_blink  <= '0;
      active_digits <= {NUM_DIGITS{BLANK_CODE}};
      active_dp     <= '0;
      active_blink  <= '0;
      pending       <= 1'b0;
    end else begin
      if (frame_wrap_c && pending) begin
        active_digits <= shadow_digits;
        active_dp     <= shadow_dp;
        active_blink  <= shadow_blink;
      end
      if (load) begin
        shadow_digits <= digit_data;
        shadow_dp     <= dp_in;
        shadow_blink  <= blink_en;
        pending       <= 1'b1;
      end else if (frame_wrap_c) begin
        pending       <= 1'b0;
      end
    end
  end

  // Leading-zero mask: digit i is blankable when it and everything above are zero
  always_comb begin
    zero_run_c = 1'b1;
    lz_mask_c  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run_c   = zero_run_c & (active_digits[4*i +: 4] == 4'h0);
      lz_mask_c[i] = zero_run_c;
    end
  end

  always_comb begin
    cur_nibble_c  = active_digits[4*int'(idx) +: 4];
    blink_blank_c = active_blink[idx] & blink_phase;
    code_c        = cur_nibble_c;
    if (blink_blank_c || (lzb && lz_mask_c[idx])) begin
      code_c = BLANK_CODE;
    end
  end

  ssd_hex_decoder u_decoder (
    .code  (code_c),
    .seg_c (seg_c)
  );

  // Registered pin drive, one clock behind the scan state
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      anode   <= '1;
      cathode <= SEG_BLANK;
      dp_out  <= 1'b1;
    end else begin
      anode   <= (presc < DEAD_END) ? '1 : ~(NUM_DIGITS'(1) << idx);
      cathode <= seg_c;
      dp_out  <= blink_blank_c | ~active_dp[idx];
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver at 4 digits, 4-clock slots, 16-clock frames.
module tb_ssd_scan_driver;

  logic        board_clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  dp_in;
  logic [3:0]  blink_en;
  logic        lzb;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        dp_out;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;
  int tick_count = 0;

  logic [6:0] f_cat [4];
  logic [3:0] f_an  [4];
  logic [3:0] f_dt  [4];
  logic       f_dp  [4];
  logic       f_tick_end;
  int         f_mid_ticks;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b0000110 ^ 7'b1001010;
  localparam logic [6:0] G5 = 7'b0100100, G7 = 7'b0001111, GA = 7'b0001000;
  localparam logic [6:0] GBL = 7'h7F;

  ssd_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV_BITS(2), .DEADTIME(1), .BLINK_LOG2(1)
  ) dut (
    .board_clk  (board_clk),
    .reset      (reset),
    .load       (load),
    .digit_data (digit_data),
    .dp_in      (dp_in),
    .blink_en   (blink_en),
    .lzb        (lzb),
    .anode      (anode),
    .cathode    (cathode),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  always #5 board_clk = ~board_clk;

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    digit_data = d;
    dp_in      = dp;
    blink_en   = bl;
    load       = 1'b1;
    @(posedge board_clk); #1;
    load       = 1'b0;
  endtask

  task automatic wait_tick(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(posedge board_clk); #1;
      n++;
      if (frame_tick === 1'b1) ok = 1'b1;
    end
    if (ok) tick_count++;
  endtask

  // Called just after a frame_tick sample; records one full frame of outputs
  task automatic capture_frame();
    int s, q;
    f_mid_ticks = 0;
    for (int j = 1; j <= 16; j++) begin
      @(posedge board_clk); #1;
      s = (j - 1) / 4;
      q = (j - 1) % 4;
      if (q == 0) f_dt[s] = anode;
      if (q == 2) begin
        f_an[s]  = anode;
        f_cat[s] = cathode;
        f_dp[s]  = dp_out;
      end
      if (j < 16 && frame_tick === 1'b1) f_mid_ticks++;
    end
    f_tick_end = frame_tick;
    if (frame_tick === 1'b1) tick_count++;
  endtask

  task automatic test_reset();
    int n;
    bit ok;
    reset = 1'b1; load = 1'b0; digit_data = '0; dp_in = '0; blink_en = '0; lzb = 1'b0;
    #12;
    tests++;
    if ({anode, cathode, dp_out, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got an=%b cat=%b dp=%b tick=%b, expected 1111 1111111 1 0",
               anode, cathode, dp_out, frame_tick);
    end
    @(negedge board_clk); reset = 1'b0;
    @(posedge board_clk); #1;
    tests++;
    if (anode !== 4'b1111) begin
      fails++; $display("FAIL reset_first_deadtime: anode=%b expected 1111", anode);
    end
    @(posedge board_clk); #1;
    tests++;
    if (anode !== 4'b1110 || cathode !== GBL) begin
      fails++; $display("FAIL reset_first_slot: an=%b cat=%b expected 1110 1111111", anode, cathode);
    end
    wait_tick(n, ok);
    tests++;
    if (!ok || n != 14) begin
      fails++; $display("FAIL reset_tick_period: ok=%0d after %0d cycles, expected 14", ok, n);
    end
    capture_frame();
    for (int s = 0; s < 4; s++) begin
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << s);
      tests++;
      if (f_an[s] !== exp_an || f_dt[s] !== 4'hF || f_cat[s] !== GBL) begin
        fails++;
        $display("FAIL blank_slot%0d: an=%b dt=%b cat=%b expected %b 1111 1111111",
                 s, f_an[s], f_dt[s], f_cat[s], exp_an);
      end
    end
    tests++;
    if (f_tick_end !== 1'b1 || f_mid_ticks != 0) begin
      fails++; $display("FAIL frame_tick_16: end=%b mid=%0d expected 1 0", f_tick_end, f_mid_ticks);
    end
  endtask

  task automatic test_load_commit();
    int n, bad;
    logic [27:0] exp;
    repeat (5) begin @(posedge board_clk); #1; end
    do_load(16'h1234, 4'b0000, 4'b0000);
    n = 0; bad = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      if (cathode !== GBL) bad++;
      @(posedge board_clk); #1;
      n++;
    end
    if (cathode !== GBL) bad++;
    if (frame_tick === 1'b1) tick_count++;
    tests++;
    if (bad != 0 || frame_tick !== 1'b1) begin
      fails++; $display("FAIL no_tearing: %0d non-blank samples, tick=%b; expected 0 and 1", bad, frame_tick);
    end
    capture_frame();
    exp = {G1, G2, G3, G4};
    for (int s = 0; s < 4; s++) begin
      logic [3:0] exp_an;
      exp_an = ~(4'b0001 << s);
      tests++;
      if (f_cat[s] !== exp[7*s +: 7] || f_an[s] !== exp_an || f_dt[s] !== 4'hF || f_dp[s] !== 1'b1) begin
        fails++;
        $display("FAIL digits1234_slot%0d: cat=%b an=%b dt=%b dp=%b expected %b %b 1111 1",
                 s, f_cat[s], f_an[s], f_dt[s], f_dp[s], exp[7*s +: 7], exp_an);
      end
    end
  endtask

  task automatic test_lzb();
    int n;
    bit ok;
    logic [27:0] exp;
    lzb = 1'b1;
    do_load(16'h0070, 4'b0000, 4'b0000);
    wait_tick(n, ok);
    capture_frame();
    exp = {GBL, GBL, G7, G0};
    for (int s = 0; s < 4; s++) begin
      tests++;
      if (f_cat[s] !== exp[7*s +: 7]) begin
        fails++; $display("FAIL lzb_on_digit%0d: cat=%b expected %b", s, f_cat[s], exp[7*s +: 7]);
      end
    end
    lzb = 1'b0;
    capture_frame();
    exp = {G0, G0, G7, G0};
    for (int s = 0; s < 4; s++) begin
      tests++;
      if (f_cat[s] !== exp[7*s +: 7]) begin
        fails++; $display("FAIL lzb_off_digit%0d: cat=%b expected %b", s, f_cat[s], exp[7*s +: 7]);
      end
    end
  endtask

  task automatic test_blink();
    int n, ph;
    bit ok;
    do_load(16'h0070, 4'b0001, 4'b0001);
    wait_tick(n, ok);
    for (int f = 0; f < 4; f++) begin
      ph = (tick_count / 2) % 2;
      capture_frame();
      tests++;
      if (f_cat[0] !== (ph == 1 ? GBL : G0) || f_dp[0] !== (ph == 1 ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL blink_frame%0d: cat=%b dp=%b expected %b %b", f, f_cat[0], f_dp[0],
                 (ph == 1 ? GBL : G0), (ph == 1 ? 1'b1 : 1'b0));
      end
      tests++;
      if (f_cat[1] !== G7 || f_dp[1] !== 1'b1) begin
        fails++; $display("FAIL blink_other_frame%0d: cat=%b dp=%b expected %b 1", f, f_cat[1], f_dp[1], G7);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n, seen_a;
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    repeat (3) begin @(posedge board_clk); #1; end
    do_load(16'h5555, 4'b0000, 4'b0000);
    n = 0; seen_a = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      @(posedge board_clk); #1;
      if (cathode === GA) seen_a++;
      n++;
    end
    if (frame_tick === 1'b1) tick_count++;
    capture_frame();
    for (int s = 0; s < 4; s++) if (f_cat[s] === GA) seen_a++;
    tests++;
    if (seen_a != 0 || f_cat[0] !== G5 || f_cat[3] !== G5) begin
      fails++; $display("FAIL last_load_wins: A seen %0d, cat0=%b cat3=%b expected 0 %b %b",
                        seen_a, f_cat[0], f_cat[3], G5, G5);
    end
    // second load lands on the commit edge
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (14) begin @(posedge board_clk); #1; end
    do_load(16'h2222, 4'b0000, 4'b0000);
    tests++;
    if (frame_tick !== 1'b1) begin
      fails++; $display("FAIL coincident_tick: tick=%b expected 1", frame_tick);
    end else tick_count++;
    capture_frame();
    tests++;
    if (f_cat[0] !== G1 || f_cat[2] !== G1) begin
      fails++; $display("FAIL coincident_old: cat0=%b cat2=%b expected %b", f_cat[0], f_cat[2], G1);
    end
    capture_frame();
    tests++;
    if (f_cat[0] !== G2 || f_cat[3] !== G2) begin
      fails++; $display("FAIL coincident_new: cat0=%b cat3=%b expected %b", f_cat[0], f_cat[3], G2);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit ok;
    repeat (6) begin @(posedge board_clk); #1; end
    #3 reset = 1'b1;
    #1;
    tests++;
    if ({anode, cathode, dp_out, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got an=%b cat=%b dp=%b tick=%b, expected 1111 1111111 1 0",
               anode, cathode, dp_out, frame_tick);
    end
    @(negedge board_clk); reset = 1'b0;
    tick_count = 0;
    @(posedge board_clk); #1;
    @(posedge board_clk); #1;
    tests++;
    if (anode !== 4'b1110 || cathode !== GBL) begin
      fails++; $display("FAIL restart_digit0: an=%b cat=%b expected 1110 1111111", anode, cathode);
    end
    wait_tick(n, ok);
    tests++;
    if (!ok || n != 14) begin
      fails++; $display("FAIL restart_tick: ok=%0d after %0d cycles, expected 14", ok, n);
    end
    capture_frame();
    tests++;
    if (f_cat[0] !== GBL || f_cat[1] !== GBL || f_cat[2] !== GBL || f_cat[3] !== GBL) begin
      fails++; $display("FAIL restart_blank: cat=%b %b %b %b expected all 1111111",
                        f_cat[3], f_cat[2], f_cat[1], f_cat[0]);
    end
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_lzb();
    test_blink();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
